// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer (optional IMMGEN_AUTODECODE_EN)
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] SRC_I    = 3'b000;
  localparam logic [2:0] SRC_S    = 3'b001;
  localparam logic [2:0] SRC_U    = 3'b010;
  localparam logic [2:0] SRC_Z    = 3'b011;
  localparam logic [2:0] SRC_B    = 3'b101;
  localparam logic [2:0] SRC_J    = 3'b110;
  localparam logic [2:0] SRC_AUTO = 3'b111;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state;
  logic [2:0]        eff_src;
  logic              bad_op;
  logic [31:0]       raw;
  logic [XLEN-1:0]   new_imm;
  logic [2:0]        new_type;
  logic              new_err;
  logic [XLEN-1:0]   skid_imm;
  logic [2:0]        skid_type;
  logic [TAG_W-1:0]  skid_tag;
  logic              skid_err;
  logic              accept;
  logic              pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Resolve the effective select code; auto mode derives it from the opcode
  always_comb begin
    eff_src = in_imm_src;
    bad_op  = 1'b0;
    if (in_imm_src == SRC_AUTO) begin
`ifdef IMMGEN_AUTODECODE_EN
      case (in_instr[6:0])
        7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: eff_src = SRC_I;
        7'b0100011: eff_src = SRC_S;
        7'b1100011: eff_src = SRC_B;
        7'b0110111, 7'b0010111: eff_src = SRC_U;
        7'b1101111: eff_src = SRC_J;
        7'b1110011: eff_src = in_instr[14] ? SRC_Z : SRC_I;
        default:    bad_op  = 1'b1;
      endcase
`else
      // Opcode is ignored here; the reduction folds away and bad_op stays 1
      bad_op = 1'b1 | (&in_instr[6:0]);
`endif
    end
  end

  // Assemble the 32-bit immediate (already sign-extended) and widen to XLEN
  always_comb begin
    raw      = '0;
    new_err  = 1'b0;
    new_type = eff_src;
    case (eff_src)
      SRC_I: raw = {{20{in_instr[31]}}, in_instr[31:20]};
      SRC_S: raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SRC_B: raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
      SRC_U: raw = {in_instr[31:12], 12'b0};
      SRC_J: raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
      SRC_Z: raw = {27'b0, in_instr[19:15]};
      default: begin
        new_err  = 1'b1;
        new_type = in_imm_src;
      end
    endcase
    if (bad_op) begin
      raw      = '0;
      new_err  = 1'b1;
      new_type = in_imm_src;
    end
    // Z keeps bit 31 clear, so the signed widening is a zero extension for it
    new_imm = XLEN'($signed(raw));
  end

  // Skid-buffer FSM: main register drives the outputs, skid absorbs one stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_type  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      skid_imm  <= '0;
      skid_type <= '0;
      skid_tag  <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_imm   <= new_imm;
            out_type  <= new_type;
            out_tag   <= in_tag;
            out_err   <= new_err;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            out_imm  <= new_imm;
            out_type <= new_type;
            out_tag  <= in_tag;
            out_err  <= new_err;
          end else if (accept) begin
            skid_imm  <= new_imm;
            skid_type <= new_type;
            skid_tag  <= in_tag;
            skid_err  <= new_err;
            in_ready  <= 1'b0;
            state     <= FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out_imm  <= skid_imm;
            out_type <= skid_type;
            out_tag  <= skid_tag;
            out_err  <= skid_err;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard testbench for imm_gen_pipe (XLEN 32 and 64 instances)
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [2:0]  out_type32;
  logic [3:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [2:0]  out_type64;
  logic [3:0]  out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_type(out_type32), .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_type(out_type64), .out_tag(out_tag64), .out_err(out_err64)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [2:0]  src;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        err;
  } vec_t;

  exp_t q[$];
  exp_t pend;
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_acc;

  // Reference decoder built from the bit-field definitions, 64-bit result
  function automatic exp_t model(input logic [2:0] src, input logic [31:0] i, input logic [3:0] tag);
    exp_t m;
    logic [2:0] r;
    bit ok;
    r = src;
    ok = 1'b1;
    if (src == 3'b111) begin
`ifdef IMMGEN_AUTODECODE_EN
      case (i[6:0])
        7'h03, 7'h13, 7'h1B, 7'h67: r = 3'b000;
        7'h23: r = 3'b001;
        7'h63: r = 3'b101;
        7'h37, 7'h17: r = 3'b010;
        7'h6F: r = 3'b110;
        7'h73: r = i[14] ? 3'b011 : 3'b000;
        default: ok = 1'b0;
      endcase
`else
      ok = 1'b0;
`endif
    end
    m.tag = tag;
    m.err = 1'b0;
    m.typ = r;
    m.imm = 64'd0;
    if (!ok) begin
      m.err = 1'b1;
      m.typ = src;
    end else begin
      case (r)
        3'b000: m.imm = {{52{i[31]}}, i[31:20]};
        3'b001: m.imm = {{52{i[31]}}, i[31:25], i[11:7]};
        3'b101: m.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        3'b010: m.imm = {{32{i[31]}}, i[31:12], 12'b0};
        3'b110: m.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        3'b011: m.imm = {59'd0, i[19:15]};
        default: begin
          m.err = 1'b1;
          m.typ = src;
        end
      endcase
    end
    return m;
  endfunction

  // One cycle at the falling edge: check handshake and head entry, then advance
  task automatic tick();
    exp_t e;
    bit exp_rdy;
    bit exp_ov;
    last_acc = 1'b0;
    exp_rdy = (q.size() < 2);
    exp_ov  = (q.size() != 0);
    checks++;
    if (in_ready32 !== exp_rdy || in_ready64 !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b/%b expected %b", in_ready32, in_ready64, exp_rdy);
    end
    checks++;
    if (out_valid32 !== exp_ov || out_valid64 !== exp_ov) begin
      errors++;
      $display("FAIL out_valid: got %b/%b expected %b", out_valid32, out_valid64, exp_ov);
    end
    if (q.size() != 0) begin
      e = q[0];
      checks++;
      if (out_imm32 !== e.imm[31:0] || out_imm64 !== e.imm || out_type32 !== e.typ ||
          out_type64 !== e.typ || out_tag32 !== e.tag || out_tag64 !== e.tag ||
          out_err32 !== e.err || out_err64 !== e.err) begin
        errors++;
        $display("FAIL out_entry: got imm=%h/%h type=%0d/%0d tag=%0d/%0d err=%b/%b expected imm=%h type=%0d tag=%0d err=%b",
                 out_imm32, out_imm64, out_type32, out_type64, out_tag32, out_tag64,
                 out_err32, out_err64, e.imm, e.typ, e.tag, e.err);
      end
      if (out_ready) void'(q.pop_front());
    end
    if (in_valid && exp_rdy) begin
      q.push_back(pend);
      last_acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] src, input logic [31:0] instr, input exp_t e);
    in_valid   = 1'b1;
    in_imm_src = src;
    in_instr   = instr;
    in_tag     = e.tag;
    pend       = e;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_acc) break;
    end
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of tag %0d", e.tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_imm_src = '0;
    in_tag = '0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1 ||
        out_imm32 !== 32'd0 || out_imm64 !== 64'd0 || out_type32 !== 3'd0 || out_tag32 !== 4'd0 ||
        out_err32 !== 1'b0 || out_err64 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b imm=%h type=%0d tag=%0d err=%b expected 0 1 0 0 0 0",
               out_valid32, in_ready32, out_imm64, out_type32, out_tag32, out_err32);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    exp_t e;
    vecs.delete();
    vecs.push_back({3'b000, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0});
    vecs.push_back({3'b001, 32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'b001, 1'b0});
    vecs.push_back({3'b101, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'b101, 1'b0});
    vecs.push_back({3'b110, 32'h0010006F, 64'h0000000000000800, 3'b110, 1'b0});
    vecs.push_back({3'b011, 32'h300FD073, 64'h000000000000001F, 3'b011, 1'b0});
    vecs.push_back({3'b010, 32'h800000B7, 64'hFFFFFFFF80000000, 3'b010, 1'b0});
    vecs.push_back({3'b010, 32'h123450B7, 64'h0000000012345000, 3'b010, 1'b0});
    vecs.push_back({3'b100, 32'hFE000EE3, 64'h0, 3'b100, 1'b1});
`ifdef IMMGEN_AUTODECODE_EN
    vecs.push_back({3'b111, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'b101, 1'b0});
    vecs.push_back({3'b111, 32'h00000033, 64'h0, 3'b111, 1'b1});
    vecs.push_back({3'b111, 32'h300FD073, 64'h000000000000001F, 3'b011, 1'b0});
    vecs.push_back({3'b111, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0});
`else
    vecs.push_back({3'b111, 32'hFE000EE3, 64'h0, 3'b111, 1'b1});
    vecs.push_back({3'b111, 32'hFFF00093, 64'h0, 3'b111, 1'b1});
`endif
    out_ready = 1'b1;
    foreach (vecs[n]) begin
      e.imm = vecs[n].imm;
      e.typ = vecs[n].typ;
      e.err = vecs[n].err;
      e.tag = 4'(n);
      send(vecs[n].src, vecs[n].instr, e);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [31:0] ins;
    idx = 0;
    ins = 32'h00000013;
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (idx < 8) begin
        ins = {12'(idx * 37 + 1), 13'd0, 7'h13};
        in_valid   = 1'b1;
        in_imm_src = 3'b000;
        in_instr   = ins;
        in_tag     = 4'(idx);
        pend       = model(3'b000, ins, 4'(idx));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_acc) idx++;
      if (idx == 8 && q.size() == 0) break;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got %0d sent %0d pending expected 8 sent 0 pending", idx, q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [2:0]  src;
    logic [6:0]  ops [9];
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h73};
    for (int cyc = 0; cyc < 300; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[6:0] = ops[$urandom_range(0, 8)];
      src = 3'($urandom_range(0, 7));
      in_instr   = ins;
      in_imm_src = src;
      in_tag     = 4'(cyc);
      pend       = model(src, ins, 4'(cyc));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    out_ready = 1'b0;
    e = model(3'b000, 32'h00100093, 4'd1);
    send(3'b000, 32'h00100093, e);
    e = model(3'b000, 32'h00200093, 4'd2);
    send(3'b000, 32'h00200093, e);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1 ||
        out_tag32 !== 4'd0 || out_imm64 !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b/%b ready=%b/%b tag=%0d imm=%h expected 0 1 0 0",
               out_valid32, out_valid64, in_ready32, in_ready64, out_tag32, out_imm64);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    e = model(3'b010, 32'h123450B7, 4'd9);
    send(3'b010, 32'h123450B7, e);
    checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 4'd9 || out_tag64 !== 4'd9) begin
      errors++;
      $display("FAIL post_reset_first: got valid=%b tag=%0d/%0d expected 1 9", out_valid32, out_tag32, out_tag64);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
